// File: rtl/snake_body_if.sv
// Move handshake from game control and the segment stream toward the renderer.
// master = game control / renderer side, slave = snake_body.
interface snake_body_if;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_grow;
    logic       move_ready;
    logic [4:0] snake_x;
    logic [3:0] snake_y;
    logic [1:0] snake_dir;
    logic       snake_first;
    logic       snake_last;
    logic       snake_valid;

    modport master (
        output move_valid, move_dir, move_grow,
        input  move_ready,
        input  snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid
    );

    modport slave (
        input  move_valid, move_dir, move_grow,
        output move_ready,
        output snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid
    );
endinterface

// File: rtl/snake_body.sv
// Snake body store: head coordinate plus a ring of link directions, streamed head-to-tail.
// Optional macro SNAKE_WRAP_EN: playfield edges wrap instead of causing wall hits.
module snake_body #(
    parameter int MAX_LEN     = 64,
    parameter int GAME_WIDTH  = 18,
    parameter int GAME_HEIGHT = 13,
    parameter int START_X     = 5,
    parameter int START_Y     = 7,
    parameter int START_LEN   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       game_rst,
    snake_body_if.slave                bus,
    output logic [4:0]                 head_x,
    output logic [3:0]                 head_y,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic                       full,
    output logic                       pass_done,
    output logic                       self_hit,
    output logic                       wall_hit
);
    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = PW + 1;

    localparam logic [0:0] ST_GAP    = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]    state;
    logic [1:0]    ring [MAX_LEN];
    logic [PW-1:0] head_ptr;
    logic [LW-1:0] idx;
    logic [4:0]    cur_x;
    logic [3:0]    cur_y;
    logic          hit_flag;

    logic [1:0]    link_head;
    logic [1:0]    eff_dir;
    logic [1:0]    seg_dir;
    logic [5:0]    nx;
    logic [4:0]    ny;
    logic          in_field;
    logic          dead;
    logic          take;
    logic          apply;
    logic [PW-1:0] new_ptr;

    function automatic logic [1:0] opp(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    // One extra bit keeps the unwrapped value so stepping off either edge is visible.
    function automatic logic [5:0] step_x(input logic [4:0] x, input logic [1:0] d);
        logic [5:0] v;
        case (d)
            2'd0:    v = {1'b0, x} + 6'd1;
            2'd1:    v = {1'b0, x} - 6'd1;
            default: v = {1'b0, x};
        endcase
`ifdef SNAKE_WRAP_EN
        if (v == 6'd0)                    v = 6'(GAME_WIDTH);
        else if (v == 6'(GAME_WIDTH + 1)) v = 6'd1;
`endif
        return v;
    endfunction

    function automatic logic [4:0] step_y(input logic [3:0] y, input logic [1:0] d);
        logic [4:0] v;
        case (d)
            2'd2:    v = {1'b0, y} + 5'd1;
            2'd3:    v = {1'b0, y} - 5'd1;
            default: v = {1'b0, y};
        endcase
`ifdef SNAKE_WRAP_EN
        if (v == 5'd0)                     v = 5'(GAME_HEIGHT);
        else if (v == 5'(GAME_HEIGHT + 1)) v = 5'd1;
`endif
        return v;
    endfunction

    always_comb begin
        link_head = ring[head_ptr];
        // ring[head_ptr] points tail-ward, so asking for that direction is a reversal
        eff_dir   = (bus.move_dir == link_head) ? opp(link_head) : bus.move_dir;
        nx        = step_x(head_x, eff_dir);
        ny        = step_y(head_y, eff_dir);
        in_field  = (nx >= 6'd1) && (nx <= 6'(GAME_WIDTH)) &&
                    (ny >= 5'd1) && (ny <= 5'(GAME_HEIGHT));
        dead      = self_hit | wall_hit | hit_flag;
        take      = (state == ST_GAP) && bus.move_valid;
        apply     = take && !dead && in_field;
        new_ptr   = head_ptr - PW'(1);
        seg_dir   = ring[head_ptr + idx[PW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst || game_rst) begin
            state    <= ST_GAP;
            head_x   <= 5'(START_X);
            head_y   <= 4'(START_Y);
            length   <= LW'(START_LEN);
            head_ptr <= '0;
            for (int unsigned i = 0; i < MAX_LEN; i++) ring[i] <= 2'd1;
            full      <= 1'b0;
            self_hit  <= 1'b0;
            wall_hit  <= 1'b0;
            hit_flag  <= 1'b0;
            idx       <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            pass_done <= 1'b0;
            bus.move_ready  <= 1'b0;
            bus.snake_x     <= '0;
            bus.snake_y     <= '0;
            bus.snake_dir   <= '0;
            bus.snake_first <= 1'b0;
            bus.snake_last  <= 1'b0;
            bus.snake_valid <= 1'b0;
        end else begin
            case (state)
                ST_GAP: begin
                    bus.snake_valid <= 1'b0;
                    bus.snake_first <= 1'b0;
                    bus.snake_last  <= 1'b0;
                    bus.snake_x     <= '0;
                    bus.snake_y     <= '0;
                    bus.snake_dir   <= '0;
                    pass_done       <= 1'b1;
                    bus.move_ready  <= take;
                    self_hit        <= self_hit | hit_flag;
                    hit_flag        <= 1'b0;
`ifndef SNAKE_WRAP_EN
                    if (take && !dead && !in_field) wall_hit <= 1'b1;
`endif
                    if (apply) begin
                        head_x        <= nx[4:0];
                        head_y        <= ny[3:0];
                        head_ptr      <= new_ptr;
                        ring[new_ptr] <= opp(eff_dir);
                        if (bus.move_grow && !full) begin
                            length <= length + LW'(1);
                            full   <= (length == LW'(MAX_LEN - 1));
                        end
                        cur_x <= nx[4:0];
                        cur_y <= ny[3:0];
                    end else begin
                        cur_x <= head_x;
                        cur_y <= head_y;
                    end
                    idx   <= '0;
                    state <= ST_STREAM;
                end
                default: begin
                    pass_done       <= 1'b0;
                    bus.move_ready  <= 1'b0;
                    bus.snake_valid <= 1'b1;
                    bus.snake_x     <= cur_x;
                    bus.snake_y     <= cur_y;
                    bus.snake_dir   <= seg_dir;
                    bus.snake_first <= (idx == '0);
                    bus.snake_last  <= (idx == length - LW'(1));
                    cur_x <= 5'(step_x(cur_x, seg_dir));
                    cur_y <= 4'(step_y(cur_y, seg_dir));
                    if (idx != '0 && cur_x == head_x && cur_y == head_y) hit_flag <= 1'b1;
                    idx <= idx + LW'(1);
                    if (idx == length - LW'(1)) state <= ST_GAP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snake_body.sv
// Self-checking bench for snake_body against a queue-based model of the snake.
// A smaller ring depth is used so the full condition and ring wrap are reachable.
module tb_snake_body;
    localparam int MAX_LEN = 16;
    localparam int LW      = $clog2(MAX_LEN) + 1;
    localparam int GW      = 18;
    localparam int GH      = 13;
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic game_rst = 1'b0;
    logic [4:0]    head_x;
    logic [3:0]    head_y;
    logic [LW-1:0] length;
    logic full, pass_done, self_hit, wall_hit;

    snake_body_if bus ();

    snake_body #(
        .MAX_LEN(MAX_LEN), .GAME_WIDTH(GW), .GAME_HEIGHT(GH),
        .START_X(5), .START_Y(7), .START_LEN(3)
    ) dut (
        .clk(clk), .rst(rst), .game_rst(game_rst), .bus(bus.slave),
        .head_x(head_x), .head_y(head_y), .length(length), .full(full),
        .pass_done(pass_done), .self_hit(self_hit), .wall_hit(wall_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: head position, length, and links kept head-first (front = newest).
    int m_hx, m_hy, m_len;
    bit m_self, m_pend, m_wall;
    logic [1:0] m_links[$];

    logic [14:0]    exp_seg [MAX_LEN];
    logic [14:0]    obs_seg [MAX_LEN];
    int             exp_n;
    logic [LW+14:0] exp_gap, obs_gap;
    logic           stream_ctl;

    function automatic logic [1:0] opp(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    function automatic int dx(input logic [1:0] d);
        return (d == 2'd0) ? 1 : (d == 2'd1) ? -1 : 0;
    endfunction

    function automatic int dy(input logic [1:0] d);
        return (d == 2'd2) ? 1 : (d == 2'd3) ? -1 : 0;
    endfunction

    function automatic int wrap(input int v, input int hi);
        if (WRAP && v < 1)  return hi;
        if (WRAP && v > hi) return 1;
        return v;
    endfunction

    function void m_reset();
        m_hx = 5; m_hy = 7; m_len = 3;
        m_self = 0; m_pend = 0; m_wall = 0;
        m_links.delete();
        for (int i = 0; i < MAX_LEN; i++) m_links.push_back(2'd1);
    endfunction

    // Expected segments of the coming pass, and whether they include a head overlap.
    function void m_walk();
        int x, y;
        x = m_hx; y = m_hy; exp_n = m_len; m_pend = 0;
        for (int i = 0; i < m_len; i++) begin
            if (i > 0 && x == m_hx && y == m_hy) m_pend = 1;
            exp_seg[i] = {1'b1, 1'(i == 0), 1'(i == m_len - 1), m_links[i], 4'(y), 5'(x)};
            x = wrap(x + dx(m_links[i]), GW);
            y = wrap(y + dy(m_links[i]), GH);
        end
    endfunction

    function void m_gap(input bit mv, input logic [1:0] d, input bit g);
        logic [1:0] heading, eff;
        int nx, ny;
        m_self = m_self | m_pend;
        m_pend = 0;
        if (mv && !m_self && !m_wall) begin
            heading = opp(m_links[0]);
            eff = (d == opp(heading)) ? heading : d;
            nx = wrap(m_hx + dx(eff), GW);
            ny = wrap(m_hy + dy(eff), GH);
            if (nx < 1 || nx > GW || ny < 1 || ny > GH) begin
                m_wall = 1;
            end else begin
                m_hx = nx; m_hy = ny;
                m_links.push_front(opp(eff));
                void'(m_links.pop_back());
                if (g && m_len < MAX_LEN) m_len++;
            end
        end
        exp_gap = {1'b1, 1'b0, mv, m_self, m_wall, 1'(m_len == MAX_LEN),
                   LW'(m_len), 4'(m_hy), 5'(m_hx)};
    endfunction

    function automatic logic [LW+14:0] cur_gap();
        return {pass_done, bus.snake_valid, bus.move_ready, self_hit, wall_hit, full,
                length, head_y, head_x};
    endfunction

    // Precondition: sitting in a GAP cycle. Runs one full pass, leaves us in the next GAP.
    task automatic run_pass(input bit mv, input logic [1:0] d, input bit g);
        m_walk();
        stream_ctl = 1'b0;
        bus.move_valid = mv;
        bus.move_dir   = d;
        bus.move_grow  = g;
        for (int i = 0; i < exp_n; i++) begin
            @(negedge clk);
            obs_seg[i] = {bus.snake_valid, bus.snake_first, bus.snake_last,
                          bus.snake_dir, bus.snake_y, bus.snake_x};
            stream_ctl = stream_ctl | bus.move_ready | pass_done;
        end
        @(negedge clk);
        obs_gap = cur_gap();
        bus.move_valid = 1'b0;
        m_gap(mv, d, g);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (cur_gap() !== {6'b0, LW'(3), 4'd7, 5'd5}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", cur_gap(), {6'b0, LW'(3), 4'd7, 5'd5});
        end
        checks++;
        if ({bus.snake_first, bus.snake_last, bus.snake_x, bus.snake_y, bus.snake_dir} !== 13'd0) begin
            failures++;
            $display("FAIL reset_bus got=%b exp=0", {bus.snake_first, bus.snake_last, bus.snake_x});
        end
        rst = 1'b0;
        @(negedge clk);
        m_reset();
        checks++;
        if (pass_done !== 1'b1 || bus.snake_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_gap got pd=%b v=%b exp pd=1 v=0", pass_done, bus.snake_valid);
        end
        run_pass(1'b0, 2'd0, 1'b0);
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (obs_seg[i] !== exp_seg[i]) begin
                failures++;
                $display("FAIL reset_seg%0d got=%h exp=%h", i, obs_seg[i], exp_seg[i]);
            end
        end
        checks++;
        if (obs_seg[2] !== {1'b1, 1'b0, 1'b1, 2'd1, 4'd7, 5'd3}) begin
            failures++;
            $display("FAIL reset_tail got=%h exp=%h", obs_seg[2], {1'b1, 1'b0, 1'b1, 2'd1, 4'd7, 5'd3});
        end
        checks++;
        if (obs_gap !== exp_gap || stream_ctl !== 1'b0) begin
            failures++;
            $display("FAIL reset_gap got=%h/%b exp=%h/0", obs_gap, stream_ctl, exp_gap);
        end
    endtask

    task automatic test_grow_self();
        logic [1:0] dirs [6] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
        bit         grows[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            run_pass(1'b1, dirs[k], grows[k]);
            for (int i = 0; i < exp_n; i++) begin
                checks++;
                if (obs_seg[i] !== exp_seg[i]) begin
                    failures++;
                    $display("FAIL grow_self_p%0d_seg%0d got=%h exp=%h", k, i, obs_seg[i], exp_seg[i]);
                end
            end
            checks++;
            if (obs_gap !== exp_gap || stream_ctl !== 1'b0) begin
                failures++;
                $display("FAIL grow_self_gap%0d got=%h/%b exp=%h/0", k, obs_gap, stream_ctl, exp_gap);
            end
        end
        // last move was acked while dead: head stays at (6,7), length 5, self_hit set
        checks++;
        if ({self_hit, length, head_y, head_x} !== {1'b1, LW'(5), 4'd7, 5'd6}) begin
            failures++;
            $display("FAIL self_hit_final got=%h exp=%h", {self_hit, length, head_y, head_x},
                     {1'b1, LW'(5), 4'd7, 5'd6});
        end
    endtask

    task automatic test_reversal();
        do_reset();
        run_pass(1'b1, 2'd1, 1'b0);
        checks++;
        if (obs_gap !== exp_gap || {head_x, head_y, length} !== {5'd6, 4'd7, LW'(3)}) begin
            failures++;
            $display("FAIL reversal got=%h exp=%h", obs_gap, exp_gap);
        end
    endtask

    task automatic test_wall();
        do_reset();
        for (int k = 0; k < 15; k++) begin
            run_pass(1'b1, (k == 14) ? 2'd2 : 2'd0, 1'b0);
            if (k >= 12) begin
                for (int i = 0; i < exp_n; i++) begin
                    checks++;
                    if (obs_seg[i] !== exp_seg[i]) begin
                        failures++;
                        $display("FAIL wall_p%0d_seg%0d got=%h exp=%h", k, i, obs_seg[i], exp_seg[i]);
                    end
                end
                checks++;
                if (obs_gap !== exp_gap) begin
                    failures++;
                    $display("FAIL wall_gap%0d got=%h exp=%h", k, obs_gap, exp_gap);
                end
            end
        end
        run_pass(1'b0, 2'd0, 1'b0);
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (obs_seg[i] !== exp_seg[i]) begin
                failures++;
                $display("FAIL wall_after_seg%0d got=%h exp=%h", i, obs_seg[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 14; k++) begin
            run_pass(1'b1, (k == 13) ? 2'd2 : 2'd0, 1'b1);
            if (k >= 12) begin
                checks++;
                if (obs_gap !== exp_gap) begin
                    failures++;
                    $display("FAIL full_gap%0d got=%h exp=%h", k, obs_gap, exp_gap);
                end
            end
        end
        run_pass(1'b0, 2'd0, 1'b0);
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (obs_seg[i] !== exp_seg[i]) begin
                failures++;
                $display("FAIL full_seg%0d got=%h exp=%h", i, obs_seg[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_game_rst();
        do_reset();
        run_pass(1'b1, 2'd0, 1'b1);
        bus.move_valid = 1'b1;
        bus.move_dir   = 2'd2;
        bus.move_grow  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        game_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cur_gap() !== {6'b0, LW'(3), 4'd7, 5'd5} || bus.snake_first !== 1'b0) begin
            failures++;
            $display("FAIL game_rst_state got=%h exp=%h", cur_gap(), {6'b0, LW'(3), 4'd7, 5'd5});
        end
        game_rst = 1'b0;
        bus.move_valid = 1'b0;
        @(negedge clk);
        m_reset();
        checks++;
        if (pass_done !== 1'b1 || bus.move_ready !== 1'b0) begin
            failures++;
            $display("FAIL game_rst_gap got pd=%b rdy=%b exp pd=1 rdy=0", pass_done, bus.move_ready);
        end
        run_pass(1'b0, 2'd0, 1'b0);
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (obs_seg[i] !== exp_seg[i]) begin
                failures++;
                $display("FAIL game_rst_seg%0d got=%h exp=%h", i, obs_seg[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_random();
        bit mv, g;
        logic [1:0] d;
        do_reset();
        for (int k = 0; k < 80; k++) begin
            if (m_self || m_wall || m_pend) do_reset();
            mv = ($urandom % 4) != 0;
            g  = ($urandom % 3) == 0;
            d  = 2'($urandom % 4);
            run_pass(mv, d, g);
            for (int i = 0; i < exp_n; i++) begin
                checks++;
                if (obs_seg[i] !== exp_seg[i]) begin
                    failures++;
                    $display("FAIL rand_p%0d_seg%0d got=%h exp=%h", k, i, obs_seg[i], exp_seg[i]);
                end
            end
            checks++;
            if (obs_gap !== exp_gap || stream_ctl !== 1'b0) begin
                failures++;
                $display("FAIL rand_gap%0d got=%h/%b exp=%h/0", k, obs_gap, stream_ctl, exp_gap);
            end
        end
    endtask

    initial begin
        bus.move_valid = 1'b0;
        bus.move_dir   = 2'd0;
        bus.move_grow  = 1'b0;
        test_reset();
        test_grow_self();
        test_reversal();
        test_wall();
        test_full();
        test_game_rst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
